// File: rtl/vmu_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vmu_mem_arbiter_pkg
//   Shared types for the VMU memory arbiter slice.
//   - vmu_req_id_e : identifies the requesting engine (LD = load, ST = store).
//   - other_req()  : returns the opposite requester, used for round-robin.
// -----------------------------------------------------------------------------
package vmu_mem_arbiter_pkg;

    typedef enum logic {
        REQ_LD = 1'b0,
        REQ_ST = 1'b1
    } vmu_req_id_e;

    function automatic vmu_req_id_e other_req(input vmu_req_id_e id);
        return (id == REQ_LD) ? REQ_ST : REQ_LD;
    endfunction

endpackage

// File: rtl/vmu_id_fifo.sv
// -----------------------------------------------------------------------------
// vmu_id_fifo
//   In-order FIFO of requester IDs for outstanding memory transactions.
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, push_id enqueue an ID (ignored when full)
//   pop           dequeue the head (ignored when empty)
//   head_id       ID at the head of the FIFO
//   full, empty   occupancy flags
//   count         number of stored IDs (0..DEPTH)
// -----------------------------------------------------------------------------
module vmu_id_fifo
    import vmu_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  vmu_req_id_e              push_id,
    input  logic                     pop,
    output vmu_req_id_e              head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    vmu_req_id_e      id_mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head_id = id_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, and the pointers/count carry validity.
    always_ff @(posedge clk) begin
        if (push_ok) id_mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/vmu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vmu_mem_arbiter
//   Shares one data-memory request port between the vector load engine (LD)
//   and the vector store engine (ST). Round-robin arbitration, combinational
//   request forwarding, and in-order response routing via an ID FIFO.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ld_req_en_i/addr_i       LD request (held until ld_grant_o)
//   ld_grant_o               LD request accepted this cycle
//   ld_resp_valid_o/data_o   LD read data, routed from memory same cycle
//   st_req_en_i/addr/data_i  ST request (held until st_grant_o)
//   st_grant_o               ST request accepted this cycle
//   st_ack_o                 ST write completion
//   mem_req_o/we/addr/wdata  memory request (we: 1 = write from ST)
//   mem_ready_i              memory accepts request this cycle
//   mem_rvalid_i/rdata_i     in-order memory response
//   outstanding_o            in-flight transaction count
//   err_o                    sticky: response with nothing outstanding
//
// Optional build macro VMU_ARB_PERF_EN adds 32-bit wrapping counters:
//   perf_ld_grants_o, perf_st_grants_o, perf_conflict_cycles_o.
// -----------------------------------------------------------------------------
module vmu_mem_arbiter
    import vmu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ld_req_en_i,
    input  logic [ADDR_WIDTH-1:0]                ld_req_addr_i,
    output logic                                 ld_grant_o,
    output logic                                 ld_resp_valid_o,
    output logic [DATA_WIDTH-1:0]                ld_resp_data_o,
    input  logic                                 st_req_en_i,
    input  logic [ADDR_WIDTH-1:0]                st_req_addr_i,
    input  logic [DATA_WIDTH-1:0]                st_req_data_i,
    output logic                                 st_grant_o,
    output logic                                 st_ack_o,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic                                 mem_ready_i,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
`ifdef VMU_ARB_PERF_EN
    output logic [31:0]                          perf_ld_grants_o,
    output logic [31:0]                          perf_st_grants_o,
    output logic [31:0]                          perf_conflict_cycles_o,
`endif
    output logic                                 err_o
);

    vmu_req_id_e prio_r;
    vmu_req_id_e prio_next;
    vmu_req_id_e winner;
    vmu_req_id_e head_id;

    logic fifo_full;
    logic fifo_empty;
    logic grant;
    logic pop;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner = REQ_LD;
        if (ld_req_en_i && st_req_en_i) winner = prio_r;
        else if (st_req_en_i)           winner = REQ_ST;
    end

    // Outputs are forced inactive while reset is asserted, not just after it.
    assign mem_req_o   = ~rst & (ld_req_en_i | st_req_en_i) & ~fifo_full;
    assign grant       = mem_req_o & mem_ready_i;
    assign ld_grant_o  = grant & (winner == REQ_LD);
    assign st_grant_o  = grant & (winner == REQ_ST);
    assign mem_we_o    = mem_req_o & (winner == REQ_ST);
    assign mem_addr_o  = !mem_req_o          ? '0 :
                         (winner == REQ_ST)  ? st_req_addr_i : ld_req_addr_i;
    assign mem_wdata_o = mem_we_o ? st_req_data_i : '0;

    // Responses are in order, so the FIFO head names their owner.
    assign pop             = ~rst & mem_rvalid_i & ~fifo_empty;
    assign ld_resp_valid_o = pop & (head_id == REQ_LD);
    assign ld_resp_data_o  = ld_resp_valid_o ? mem_rdata_i : '0;
    assign st_ack_o        = pop & (head_id == REQ_ST);
    assign outstanding_o   = fifo_count;

    // Round-robin: the requester just served yields priority to the other.
    always_comb begin
        prio_next = prio_r;
        if (grant) prio_next = other_req(winner);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio_r <= REQ_LD;
        else     prio_r <= prio_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             err_o <= 1'b0;
        else if (mem_rvalid_i && fifo_empty) err_o <= 1'b1;
    end

    vmu_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (grant),
        .push_id (winner),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef VMU_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ld_grants_o       <= '0;
            perf_st_grants_o       <= '0;
            perf_conflict_cycles_o <= '0;
        end else begin
            if (ld_grant_o) perf_ld_grants_o <= perf_ld_grants_o + 32'd1;
            if (st_grant_o) perf_st_grants_o <= perf_st_grants_o + 32'd1;
            // At most one requester is granted, so any both-high cycle is a conflict.
            if (ld_req_en_i && st_req_en_i)
                perf_conflict_cycles_o <= perf_conflict_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vmu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vmu_mem_arbiter
//   Scoreboard bench: the driver issues one cycle of stimulus at a time and a
//   queue/arithmetic reference model pushes the expected per-cycle outputs,
//   granted transactions and routed responses into queues. A monitor samples
//   the DUT on the falling edge and pops/compares.
// -----------------------------------------------------------------------------
module tb_vmu_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam bit ID_LD = 1'b0;
    localparam bit ID_ST = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_req_en_i = 1'b0;
    logic [AW-1:0] ld_req_addr_i = '0;
    logic          ld_grant_o;
    logic          ld_resp_valid_o;
    logic [DW-1:0] ld_resp_data_o;
    logic          st_req_en_i = 1'b0;
    logic [AW-1:0] st_req_addr_i = '0;
    logic [DW-1:0] st_req_data_i = '0;
    logic          st_grant_o;
    logic          st_ack_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ready_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [2:0]    outstanding_o;
    logic          err_o;

    vmu_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_req_en_i     (ld_req_en_i),
        .ld_req_addr_i   (ld_req_addr_i),
        .ld_grant_o      (ld_grant_o),
        .ld_resp_valid_o (ld_resp_valid_o),
        .ld_resp_data_o  (ld_resp_data_o),
        .st_req_en_i     (st_req_en_i),
        .st_req_addr_i   (st_req_addr_i),
        .st_req_data_i   (st_req_data_i),
        .st_grant_o      (st_grant_o),
        .st_ack_o        (st_ack_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ready_i     (mem_ready_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .outstanding_o   (outstanding_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       ld_g;
        logic       st_g;
        logic [2:0] outstanding;
        logic       err;
    } cyc_t;

    typedef struct packed {
        bit            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct packed {
        bit            id;
        logic [DW-1:0] data;
    } resp_t;

    cyc_t  cyc_q[$];
    txn_t  txn_q[$];
    resp_t resp_q[$];

    // Reference model state
    bit inflight[$];
    bit turn  = ID_LD;
    bit m_err = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model's prediction for it.
    task automatic cycle(input logic l_en, input logic [AW-1:0] l_addr,
                         input logic s_en, input logic [AW-1:0] s_addr,
                         input logic [DW-1:0] s_data, input logic rdy,
                         input logic rv, input logic [DW-1:0] rd,
                         output logic l_g, output logic s_g);
        bit    full, req, win, grt, id;
        cyc_t  c;
        txn_t  t;
        resp_t r;
        @(posedge clk); #1;
        ld_req_en_i   = l_en;
        ld_req_addr_i = l_addr;
        st_req_en_i   = s_en;
        st_req_addr_i = s_addr;
        st_req_data_i = s_data;
        mem_ready_i   = rdy;
        mem_rvalid_i  = rv;
        mem_rdata_i   = rd;

        full = (inflight.size() == MAXO);
        req  = (l_en || s_en) && !full;
        win  = (l_en && s_en) ? turn : (s_en ? ID_ST : ID_LD);
        grt  = req && rdy;

        c.mem_req     = req;
        c.ld_g        = grt && (win == ID_LD);
        c.st_g        = grt && (win == ID_ST);
        c.outstanding = 3'(inflight.size());
        c.err         = m_err;
        cyc_q.push_back(c);

        if (rv) begin
            if (inflight.size() > 0) begin
                id     = inflight.pop_front();
                r.id   = id;
                r.data = (id == ID_LD) ? rd : '0;
                resp_q.push_back(r);
            end else begin
                m_err = 1'b1;
            end
        end
        if (grt) begin
            inflight.push_back(win);
            t.id    = win;
            t.addr  = (win == ID_LD) ? l_addr : s_addr;
            t.wdata = (win == ID_ST) ? s_data : '0;
            txn_q.push_back(t);
            turn = ~win;
        end
        l_g = c.ld_g;
        s_g = c.st_g;
    endtask

    task automatic idle(input logic rv, input logic [DW-1:0] rd);
        logic lg, sg;
        cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, rv, rd, lg, sg);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst          = 1'b1;
        ld_req_en_i  = 1'b0;
        st_req_en_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_ready_i  = 1'b0;
        inflight.delete();
        turn  = ID_LD;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: compares DUT outputs on the falling edge.
    initial begin
        cyc_t  c;
        txn_t  t;
        resp_t r;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("mem_req",     mem_req_o,     c.mem_req);
                check("ld_grant",    ld_grant_o,    c.ld_g);
                check("st_grant",    st_grant_o,    c.st_g);
                check("outstanding", outstanding_o, c.outstanding);
                check("err",         err_o,         c.err);
                if (!c.mem_req) check("idle_addr", mem_addr_o, '0);
            end
            if (ld_grant_o || st_grant_o) begin
                check("txn_expected", txn_q.size() != 0, 1'b1);
                if (txn_q.size() != 0) begin
                    t = txn_q.pop_front();
                    check("grant_id",  st_grant_o,  t.id);
                    check("mem_we",    mem_we_o,    t.id);
                    check("mem_addr",  mem_addr_o,  t.addr);
                    check("mem_wdata", mem_wdata_o, t.wdata);
                end
            end
            if (ld_resp_valid_o || st_ack_o) begin
                check("resp_expected", resp_q.size() != 0, 1'b1);
                if (resp_q.size() != 0) begin
                    r = resp_q.pop_front();
                    check("resp_route", st_ack_o, r.id);
                    check("resp_one_hot", ld_resp_valid_o ^ st_ack_o, 1'b1);
                    if (ld_resp_valid_o) check("ld_resp_data", ld_resp_data_o, r.data);
                end
            end else begin
                check("ld_resp_data_idle", ld_resp_data_o, '0);
            end
        end
    end

    initial begin
        logic lg, sg;
        logic          ld_p, st_p;
        logic [AW-1:0] ld_a, st_a;
        logic [DW-1:0] st_d;

        // Outputs stay inactive while reset is held, even with all inputs active.
        rst = 1'b1;
        ld_req_en_i = 1'b1; st_req_en_i = 1'b1;
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        check("rst_ld_grant",  ld_grant_o,      1'b0);
        check("rst_st_grant",  st_grant_o,      1'b0);
        check("rst_mem_req",   mem_req_o,       1'b0);
        check("rst_ld_resp",   ld_resp_valid_o, 1'b0);
        check("rst_st_ack",    st_ack_o,        1'b0);
        check("rst_count",     outstanding_o,   3'd0);
        check("rst_err",       err_o,           1'b0);
        do_reset();

        // 1: single LD request and its read response.
        cycle(1'b1, 32'h100, 1'b0, '0, '0, 1'b1, 1'b0, '0, lg, sg);
        idle(1'b1, 32'hDEAD_BEEF);

        // 2: continuous contention from reset priority -> LD,ST,LD,ST.
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h200 + i, 1'b1, 32'h300 + i, 32'hA000 + i, 1'b1, 1'b0, '0, lg, sg);
        for (int i = 0; i < 4; i++) idle(1'b1, $urandom);

        // 3: backpressure on a lone ST request, then acceptance and ack.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, '0, 1'b1, 32'h400, 32'h55AA, 1'b0, 1'b0, '0, lg, sg);
        cycle(1'b0, '0, 1'b1, 32'h400, 32'h55AA, 1'b1, 1'b0, '0, lg, sg);
        idle(1'b1, $urandom);

        // 4: fill to MAX_OUTSTANDING, blocked request, pop at full, then grant.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h500 + i, 1'b1, 32'h600 + i, 32'hB000 + i, 1'b1, 1'b0, '0, lg, sg);
        cycle(1'b1, 32'h510, 1'b1, 32'h610, 32'hB010, 1'b1, 1'b0, '0, lg, sg);
        cycle(1'b1, 32'h510, 1'b1, 32'h610, 32'hB010, 1'b1, 1'b1, 32'hC0DE_0001, lg, sg);
        cycle(1'b1, 32'h510, 1'b1, 32'h610, 32'hB010, 1'b1, 1'b0, '0, lg, sg);
        for (int i = 0; i < 4; i++) idle(1'b1, $urandom);

        // 5: push and pop in the same cycle at count 2.
        cycle(1'b0, '0, 1'b1, 32'h700, 32'h77, 1'b1, 1'b0, '0, lg, sg);
        cycle(1'b1, 32'h710, 1'b0, '0, '0, 1'b1, 1'b0, '0, lg, sg);
        cycle(1'b1, 32'h720, 1'b0, '0, '0, 1'b1, 1'b1, $urandom, lg, sg);
        idle(1'b0, '0);
        idle(1'b1, 32'h1111_2222);
        idle(1'b1, 32'h3333_4444);

        // 6: reset with transactions in flight; late response sets sticky err.
        cycle(1'b1, 32'h800, 1'b1, 32'h900, 32'h99, 1'b1, 1'b0, '0, lg, sg);
        cycle(1'b1, 32'h800, 1'b1, 32'h900, 32'h99, 1'b1, 1'b0, '0, lg, sg);
        do_reset();
        idle(1'b1, 32'hBAD0_BAD0);
        for (int i = 0; i < 3; i++) idle(1'b0, '0);
        do_reset();
        idle(1'b0, '0);

        // Randomized traffic with held-until-granted requesters.
        do_reset();
        ld_p = 1'b0; st_p = 1'b0; ld_a = '0; st_a = '0; st_d = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!ld_p && ($urandom_range(9) < 6)) begin ld_p = 1'b1; ld_a = $urandom; end
            if (!st_p && ($urandom_range(9) < 6)) begin st_p = 1'b1; st_a = $urandom; st_d = $urandom; end
            cycle(ld_p, ld_a, st_p, st_a, st_d, $urandom_range(9) < 7,
                  (inflight.size() > 0) && ($urandom_range(1) == 1), $urandom, lg, sg);
            if (lg) ld_p = 1'b0;
            if (sg) st_p = 1'b0;
        end
        for (int i = 0; i < 2 * MAXO; i++)
            if (inflight.size() > 0) idle(1'b1, $urandom);

        @(negedge clk); #1;
        check("txn_q_drained",  txn_q.size(),  0);
        check("resp_q_drained", resp_q.size(), 0);
        check("cyc_q_drained",  cyc_q.size(),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
